// File: rtl/dff_bist.sv
// dff_bist: on-chip self-test engine for a single d_ff cell.
// An 8-bit LFSR drives a pseudo-random bit stream onto dut_d. The returned q
// is checked against a LATENCY-deep delayed copy of what was driven, and a
// saturating mismatch counter plus a pass flag are reported on completion.
// Optional build macro DFF_BIST_QB_CHECK_EN: when it is defined, a cycle is
// also flagged as a mismatch if dut_qb is not the complement of dut_q.
module dff_bist #(
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  // Fibonacci step: shift right, new bit7 = b0^b2^b3^b4 (x^8+x^6+x^5+x^4+1).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               dut_d_q, dut_d_d;
  logic [15:0]        vec_cnt_q, vec_cnt_d;
  logic [3:0]         drain_cnt_q, drain_cnt_d;
  logic [LATENCY-1:0] exp_q, exp_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               mismatch;

`ifdef DFF_BIST_QB_CHECK_EN
  // q is compared against the delayed driven bit; qb must always complement q.
  always_comb begin
    mismatch = vld_q[LATENCY-1] &&
               ((dut_q != exp_q[LATENCY-1]) || (dut_qb != ~dut_q));
  end
`else
  logic unused_qb;
  assign unused_qb = dut_qb;

  // Only q is compared against the delayed driven bit.
  always_comb begin
    mismatch = vld_q[LATENCY-1] && (dut_q != exp_q[LATENCY-1]);
  end
`endif

  // Next-state logic: FSM, LFSR, counters, expected/valid pipe, error count.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    dut_d_d     = 1'b0;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;
    err_d       = err_q;

    // The pipe always shifts; a bit is only valid if it was driven in RUN.
    exp_d[0] = dut_d_q;
    vld_d[0] = (state_q == S_RUN);
    for (int unsigned i = 1; i < LATENCY; i++) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end

    if (mismatch && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          dut_d_d   = SEED_EFF[0];
          lfsr_d    = lfsr_step(SEED_EFF);
          vec_cnt_d = 16'd1;
          err_d     = '0;
          pass_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (vec_cnt_q == 16'(NUM_VECTORS)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          dut_d_d   = lfsr_q[0];
          lfsr_d    = lfsr_step(lfsr_q);
          vec_cnt_d = vec_cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        // The last compare lands on the edge entering DONE, so pass uses err_d.
        if (drain_cnt_q == 4'(LATENCY - 1)) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      dut_d_q     <= 1'b0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      exp_q       <= '0;
      vld_q       <= '0;
      err_q       <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      dut_d_q     <= dut_d_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      exp_q       <= exp_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_d     = dut_d_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_dff_bist.sv
// tb_dff_bist: directed bench for dff_bist with a behavioural d_ff beside it.
// A second instance with ERR_W=3 always sees an inverted q to exercise saturation.
module tb_dff_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_d, dut_q, dut_qb, busy, done, pass;
  logic [7:0] err_count;
  logic       d3, q3, qb3, busy3, done3, pass3;
  logic [2:0] err3;

  logic       q_ff, q3_ff;
  int         q_mode;   // 0 good, 1 stuck-at-0, 2 inverted
  logic       qb_tie;   // 1: qb wired to q instead of ~q

  int nvec = 0;
  int errs = 0;

  // d->q sequence from 8'hA5, bit i = vector i (hand-stepped LFSR).
  localparam logic [15:0] EXP_SEQ  = 16'h72A5;
  localparam int          EXP_ONES = 8;

  always #5 clk = ~clk;

  dff_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_d(dut_d), .dut_q(dut_q),
    .dut_qb(dut_qb), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  dff_bist #(.ERR_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_d(d3), .dut_q(q3),
    .dut_qb(qb3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
  );

  always @(posedge clk) begin
    q_ff  <= dut_d;
    q3_ff <= d3;
  end

  assign dut_q  = (q_mode == 1) ? 1'b0 : (q_mode == 2) ? ~q_ff : q_ff;
  assign dut_qb = qb_tie ? dut_q : ~dut_q;
  assign q3     = ~q3_ff;
  assign qb3    = ~q3;

  // Pulse start, then record dut_d, busy cycles and cycles until done (bounded).
  task automatic run_capture(input int mid_start, output logic [15:0] seq,
                             output int cyc, output int busy_cyc,
                             output logic done0, output logic pass0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seq = '0; cyc = 0; busy_cyc = 0;
    done0 = done; pass0 = pass;
    while (!done && cyc < 300) begin
      if (cyc < 16) seq[cyc] = dut_d;
      if (busy) busy_cyc++;
      start = (cyc == mid_start);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (dut_d !== 1'b0) begin errs++; $display("FAIL reset_dut_d got=%b exp=0", dut_d); end
    nvec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    nvec++; if (pass !== 1'b0) begin errs++; $display("FAIL reset_pass got=%b exp=0", pass); end
    nvec++; if (err_count !== 8'd0) begin errs++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_good(input string tag);
    logic [15:0] seq; int cyc, bc; logic d0, p0;
    q_mode = 0; qb_tie = 1'b0;
    run_capture(-1, seq, cyc, bc, d0, p0);
    nvec++; if (d0 !== 1'b0 || p0 !== 1'b0) begin errs++; $display("FAIL %s_start_clears got done=%b pass=%b exp 0/0", tag, d0, p0); end
    nvec++; if (seq !== EXP_SEQ) begin errs++; $display("FAIL %s_seq got=%h exp=%h", tag, seq, EXP_SEQ); end
    nvec++; if (bc != 17) begin errs++; $display("FAIL %s_busy_cycles got=%0d exp=17", tag, bc); end
    nvec++; if (cyc != 17) begin errs++; $display("FAIL %s_done_cycle got=%0d exp=17", tag, cyc); end
    nvec++; if (err_count !== 8'd0) begin errs++; $display("FAIL %s_err got=%0d exp=0", tag, err_count); end
    nvec++; if (pass !== 1'b1) begin errs++; $display("FAIL %s_pass got=%b exp=1", tag, pass); end
    nvec++; if (dut_d !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL %s_idle_outs got d=%b busy=%b exp 0/0", tag, dut_d, busy); end
    // done must hold in DONE without a new start
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (done !== 1'b1) begin errs++; $display("FAIL %s_done_hold got=%b exp=1", tag, done); end
  endtask

  task automatic test_stuck0;
    logic [15:0] seq; int cyc, bc; logic d0, p0;
    q_mode = 1; qb_tie = 1'b0;
    run_capture(-1, seq, cyc, bc, d0, p0);
    nvec++; if (cyc != 17) begin errs++; $display("FAIL stuck0_done_cycle got=%0d exp=17", cyc); end
    nvec++; if (err_count !== 8'(EXP_ONES)) begin errs++; $display("FAIL stuck0_err got=%0d exp=%0d", err_count, EXP_ONES); end
    nvec++; if (pass !== 1'b0) begin errs++; $display("FAIL stuck0_pass got=%b exp=0", pass); end
    q_mode = 0;
  endtask

  task automatic test_qb_tie;
    logic [15:0] seq; int cyc, bc; logic d0, p0;
    logic [7:0] exp_err; logic exp_pass;
`ifdef DFF_BIST_QB_CHECK_EN
    exp_err = 8'd16; exp_pass = 1'b0;
`else
    exp_err = 8'd0; exp_pass = 1'b1;
`endif
    q_mode = 0; qb_tie = 1'b1;
    run_capture(-1, seq, cyc, bc, d0, p0);
    nvec++; if (err_count !== exp_err) begin errs++; $display("FAIL qb_tie_err got=%0d exp=%0d", err_count, exp_err); end
    nvec++; if (pass !== exp_pass) begin errs++; $display("FAIL qb_tie_pass got=%b exp=%b", pass, exp_pass); end
    qb_tie = 1'b0;
  endtask

  task automatic test_saturate;
    logic [15:0] seq; int cyc, bc; logic d0, p0;
    q_mode = 0; qb_tie = 1'b0;
    run_capture(3, seq, cyc, bc, d0, p0);
    nvec++; if (cyc != 17) begin errs++; $display("FAIL sat_done_cycle got=%0d exp=17", cyc); end
    nvec++; if (bc != 17) begin errs++; $display("FAIL sat_busy_cycles got=%0d exp=17", bc); end
    nvec++; if (seq !== EXP_SEQ) begin errs++; $display("FAIL sat_seq got=%h exp=%h", seq, EXP_SEQ); end
    nvec++; if (done3 !== 1'b1) begin errs++; $display("FAIL sat_done3 got=%b exp=1", done3); end
    nvec++; if (err3 !== 3'd7) begin errs++; $display("FAIL sat_err3 got=%0d exp=7", err3); end
    nvec++; if (pass3 !== 1'b0) begin errs++; $display("FAIL sat_pass3 got=%b exp=0", pass3); end
    nvec++; if (err_count !== 8'd0) begin errs++; $display("FAIL sat_main_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_reset_midrun;
    q_mode = 0; qb_tie = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // first RUN cycle
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;                    // during the 5th RUN cycle
    @(posedge clk); #1;
    nvec++; if (dut_d !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errs++; $display("FAIL midrst_ctrl got d=%b busy=%b done=%b exp 0/0/0", dut_d, busy, done); end
    nvec++; if (pass !== 1'b0 || err_count !== 8'd0)
      begin errs++; $display("FAIL midrst_result got pass=%b err=%0d exp 0/0", pass, err_count); end
    rst_n = 1'b1;
    test_good("after_rst");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; q_mode = 0; qb_tie = 1'b0;
    test_reset();
    test_good("good");
    test_good("restart");
    test_stuck0();
    test_qb_tie();
    test_saturate();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
